// File: rtl/line_follow_motor_ctrl_pkg.sv
// rtl/line_follow_motor_ctrl_pkg.sv - shared steering codes and FSM encodings
package line_follow_motor_ctrl_pkg;

  // Steering codes from the line tracker
  localparam logic [1:0] TRK_STRAIGHT = 2'b11;
  localparam logic [1:0] TRK_LEFT     = 2'b10;
  localparam logic [1:0] TRK_RIGHT    = 2'b01;
  localparam logic [1:0] TRK_LOST     = 2'b00;

  // Steering FSM; encodings are visible on the fsm_state debug port
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STRAIGHT = 3'd1,
    ST_LEFT     = 3'd2,
    ST_RIGHT    = 3'd3,
    ST_SEARCH   = 3'd4,
    ST_STOP     = 3'd5
  } fsm_state_e;

  // Direction of the most recent turn, used to pick the search spin direction
  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_e;

endpackage

// File: rtl/line_follow_motor_ctrl_pwm_channel.sv
// rtl/line_follow_motor_ctrl_pwm_channel.sv - one wheel: duty ramp register and PWM compare flop
module line_follow_motor_ctrl_pwm_channel #(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                boundary,
  input  logic                force_off,
  input  logic [PWM_BITS-1:0] target,
  output logic                pwm
);

  localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(RAMP_STEP);

  logic [PWM_BITS-1:0] duty_cur_d, duty_cur_q;
  logic                pwm_d, pwm_q;

  // One bit wider than the duty so neither the step up nor the floor check can wrap
  logic [PWM_BITS:0] duty_ext;
  logic [PWM_BITS:0] tgt_ext;
  logic [PWM_BITS:0] up_sum;
  logic [PWM_BITS:0] dn_diff;
  logic [PWM_BITS:0] dn_floor;

  assign duty_ext = {1'b0, duty_cur_q};
  assign tgt_ext  = {1'b0, target};
  assign up_sum   = duty_ext + STEP;
  assign dn_diff  = duty_ext - STEP;
  assign dn_floor = tgt_ext + STEP;

  // Ramp toward target once per period; losing enable zeroes the wheel at once
  always_comb begin
    duty_cur_d = duty_cur_q;
    if (force_off) begin
      duty_cur_d = '0;
    end else if (boundary) begin
      if (duty_cur_q < target) begin
        duty_cur_d = (up_sum >= tgt_ext) ? target : up_sum[PWM_BITS-1:0];
      end else if (duty_cur_q > target) begin
        duty_cur_d = (duty_ext >= dn_floor) ? dn_diff[PWM_BITS-1:0] : target;
      end
    end
  end

  // Compare output, gated so a dropped enable silences the pin on the very next clock
  always_comb begin
    pwm_d = (pwm_cnt < duty_cur_q) && !force_off;
  end

  // Duty and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_cur_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_cur_q <= duty_cur_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/line_follow_motor_ctrl.sv
// rtl/line_follow_motor_ctrl.sv - steering FSM, lost-line search and dual PWM motor drive
module line_follow_motor_ctrl
  import line_follow_motor_ctrl_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int DUTY_FAST    = 1000,
  parameter int DUTY_SLOW    = 400,
  parameter int DUTY_SEARCH  = 600,
  parameter int RAMP_STEP    = 100,
  parameter int LOST_TIMEOUT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] track_state,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_dir,
  output logic       right_dir,
  output logic [2:0] fsm_state
);

  localparam int LOST_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);
  localparam logic [PWM_BITS-1:0] D_FAST   = PWM_BITS'(DUTY_FAST);
  localparam logic [PWM_BITS-1:0] D_SLOW   = PWM_BITS'(DUTY_SLOW);
  localparam logic [PWM_BITS-1:0] D_SEARCH = PWM_BITS'(DUTY_SEARCH);

  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
  fsm_state_e          state_d, state_q;
  turn_e               last_turn_d, last_turn_q;
  logic [LOST_W-1:0]   lost_cnt_d, lost_cnt_q;
  logic                boundary;
  logic                force_off;
  logic [PWM_BITS-1:0] left_tgt, right_tgt;

  assign boundary  = &pwm_cnt_q;
  assign force_off = !enable;

  // Free-running period counter; it keeps counting while disabled
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  // Steering decisions are taken only at the period boundary; enable low wins every cycle
  always_comb begin
    state_d     = state_q;
    last_turn_d = last_turn_q;
    lost_cnt_d  = lost_cnt_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (boundary) begin
      case (track_state)
        TRK_STRAIGHT: begin
          state_d    = ST_STRAIGHT;
          lost_cnt_d = '0;
        end
        TRK_LEFT: begin
          state_d     = ST_LEFT;
          last_turn_d = TURN_LEFT;
          lost_cnt_d  = '0;
        end
        TRK_RIGHT: begin
          state_d     = ST_RIGHT;
          last_turn_d = TURN_RIGHT;
          lost_cnt_d  = '0;
        end
        default: begin
          case (state_q)
            ST_SEARCH: begin
              if (lost_cnt_q == LOST_LAST) begin
                state_d = ST_STOP;
              end else begin
                lost_cnt_d = lost_cnt_q + 1'b1;
              end
            end
            ST_STOP: state_d = ST_STOP;
            default: begin
              state_d    = ST_SEARCH;
              lost_cnt_d = '0;
            end
          endcase
        end
      endcase
    end
  end

  // Wheel targets come from the state being entered so the ramp reacts in the same cycle
  always_comb begin
    left_tgt  = '0;
    right_tgt = '0;
    case (state_d)
      ST_STRAIGHT: begin
        left_tgt  = D_FAST;
        right_tgt = D_FAST;
      end
      ST_LEFT: begin
        left_tgt  = D_SLOW;
        right_tgt = D_FAST;
      end
      ST_RIGHT: begin
        left_tgt  = D_FAST;
        right_tgt = D_SLOW;
      end
      ST_SEARCH: begin
        if (last_turn_d == TURN_LEFT) begin
          right_tgt = D_SEARCH;
        end else begin
          left_tgt = D_SEARCH;
        end
      end
      default: begin
        left_tgt  = '0;
        right_tgt = '0;
      end
    endcase
  end

  // Counter and FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      last_turn_q <= TURN_LEFT;
      lost_cnt_q  <= '0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      state_q     <= state_d;
      last_turn_q <= last_turn_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  line_follow_motor_ctrl_pwm_channel #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_left (
    .clk       (clk),
    .reset     (reset),
    .pwm_cnt   (pwm_cnt_q),
    .boundary  (boundary),
    .force_off (force_off),
    .target    (left_tgt),
    .pwm       (left_pwm)
  );

  line_follow_motor_ctrl_pwm_channel #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_right (
    .clk       (clk),
    .reset     (reset),
    .pwm_cnt   (pwm_cnt_q),
    .boundary  (boundary),
    .force_off (force_off),
    .target    (right_tgt),
    .pwm       (right_pwm)
  );

  // Reverse drive is not used yet; both wheels always run forward
  assign left_dir  = 1'b1;
  assign right_dir = 1'b1;
  assign fsm_state = state_q;

endmodule
